// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and the seed rule for the LED pattern engine.
package led_pattern_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // One-hot at the Dir-selected end for the moving-dot modes, dark otherwise.
  function automatic logic [MAX_WIDTH-1:0] seed(input logic [1:0] mode, input logic dir,
                                                input int unsigned width);
    logic [MAX_WIDTH-1:0] s;
    s = '0;
    if (mode == MODE_SHIFT || mode == MODE_BOUNCE) begin
      s = dir ? (MAX_WIDTH'(1) << (width - 1)) : MAX_WIDTH'(1);
    end
    return s;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step prescaler: fires once every (TICK_DIV >> speed) enabled, unheld cycles.
module led_tick_div #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic       CLK_in,
  input  logic       Reset,
  input  logic       clr,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [31:0] cnt_q;
  logic [31:0] lim;

  assign lim = (32'(TICK_DIV) >> speed) - 32'd1;
  // >= so that a faster speed selected mid-count fires straight away
  assign tick = !clr && !hold && (cnt_q >= lim);

  always_ff @(posedge CLK_in) begin
    if (Reset || clr) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= tick ? '0 : cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: shift, bounce, fill and blink patterns advanced by a prescaled tick.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic             CLK_in,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Hold,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  input  logic [1:0]       Speed,
  output logic [WIDTH-1:0] LED,
  output logic             Step,
  output logic             Wrap
);

  logic [WIDTH-1:0] led_q, step_led, seed_val;
  logic [1:0]       mode_q;
  logic             bdir_q, seed_dir_q, step_q, wrap_q;
  logic             step_bdir, step_sdir, step_wrap;
  logic             mode_chg, one_hot, all_ones, tick;

  led_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .CLK_in (CLK_in),
    .Reset  (Reset),
    .clr    (!Enable || mode_chg),
    .hold   (Hold),
    .speed  (Speed),
    .tick   (tick)
  );

  assign seed_val = WIDTH'(seed(Mode, Dir, WIDTH));
  assign mode_chg = (Mode != mode_q);
  assign one_hot  = $onehot(led_q);
  assign all_ones = &led_q;

  always_comb begin
    step_led  = led_q;
    step_wrap = 1'b0;
    step_bdir = bdir_q;
    step_sdir = seed_dir_q;
    unique case (mode_q)
      MODE_SHIFT: begin
        if (!one_hot) begin
          step_led = seed_val;
        end else if (!Dir) begin
          step_led  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          step_wrap = led_q[WIDTH-1];
        end else begin
          step_led  = {led_q[0], led_q[WIDTH-1:1]};
          step_wrap = led_q[0];
        end
      end
      MODE_BOUNCE: begin
        // seed_dir_q remembers which end the period started from
        if (!one_hot) begin
          step_led  = seed_val;
          step_bdir = Dir;
          step_sdir = Dir;
        end else if (!bdir_q) begin
          step_led = led_q << 1;
          if (step_led[WIDTH-1]) begin
            step_bdir = 1'b1;
            step_wrap = seed_dir_q;
          end
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) begin
            step_bdir = 1'b0;
            step_wrap = !seed_dir_q;
          end
        end
      end
      MODE_FILL: begin
        if (all_ones) begin
          step_led  = '0;
          step_wrap = 1'b1;
        end else if (!Dir) begin
          step_led = {led_q[WIDTH-2:0], 1'b1};
        end else begin
          step_led = {1'b1, led_q[WIDTH-1:1]};
        end
      end
      MODE_BLINK: begin
        step_led  = ~led_q;
        step_wrap = all_ones;
      end
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (Reset) begin
      led_q      <= seed_val;
      mode_q     <= Mode;
      bdir_q     <= Dir;
      seed_dir_q <= Dir;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (!Enable) begin
      led_q  <= '0;
      mode_q <= Mode;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (mode_chg) begin
      led_q      <= seed_val;
      mode_q     <= Mode;
      bdir_q     <= Dir;
      seed_dir_q <= Dir;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (!Hold && tick) begin
      led_q      <= step_led;
      bdir_q     <= step_bdir;
      seed_dir_q <= step_sdir;
      step_q     <= 1'b1;
      wrap_q     <= step_wrap;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign LED  = led_q;
  assign Step = step_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: behavioural model pushes per-cycle expectations.
module tb_led_pattern_engine;

  localparam int W  = 8;
  localparam int TD = 8;
  localparam int FULL = (1 << W) - 1;
  localparam int TOP  = 1 << (W - 1);

  logic         CLK_in = 1'b0;
  logic         Reset = 1'b1, Enable = 1'b1, Hold = 1'b0, Dir = 1'b0;
  logic [1:0]   Mode = 2'd0, Speed = 2'd0;
  logic [W-1:0] LED;
  logic         Step, Wrap;

  led_pattern_engine #(
    .WIDTH    (W),
    .TICK_DIV (TD)
  ) dut (
    .CLK_in (CLK_in),
    .Reset  (Reset),
    .Enable (Enable),
    .Hold   (Hold),
    .Mode   (Mode),
    .Dir    (Dir),
    .Speed  (Speed),
    .LED    (LED),
    .Step   (Step),
    .Wrap   (Wrap)
  );

  always #5 CLK_in = ~CLK_in;

  typedef struct packed {
    logic [W-1:0] led;
    logic         step;
    logic         wrap;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: LED as a plain integer, bounce as dot position plus travel direction.
  int m_led = 0, m_cnt = 0, m_bdir = 0, m_sdir = 0, m_mode = 0;

  function automatic int seed_of(input int md, input int d);
    if (md < 2) return d ? TOP : 1;
    return 0;
  endfunction

  function automatic int pos_of(input int v);
    for (int i = 0; i < W; i++) if (v == (1 << i)) return i;
    return -1;
  endfunction

  task automatic reseed();
    m_mode = int'(Mode);
    m_led  = seed_of(m_mode, int'(Dir));
    m_bdir = int'(Dir);
    m_sdir = int'(Dir);
    m_cnt  = 0;
  endtask

  task automatic advance(output logic w);
    int p;
    w = 1'b0;
    case (m_mode)
      0: begin
        if ($countones(m_led) != 1) m_led = seed_of(0, int'(Dir));
        else if (!Dir) begin w = (m_led == TOP); m_led = w ? 1 : m_led * 2; end
        else begin w = (m_led == 1); m_led = w ? TOP : m_led / 2; end
      end
      1: begin
        if ($countones(m_led) != 1) begin
          m_led = seed_of(1, int'(Dir)); m_bdir = int'(Dir); m_sdir = int'(Dir);
        end else begin
          p = pos_of(m_led) + (m_bdir ? -1 : 1);
          if (p == W - 1) m_bdir = 1;
          if (p == 0) m_bdir = 0;
          w = (p == (m_sdir ? W - 1 : 0));
          m_led = (p >= 0 && p < W) ? (1 << p) : 0;
        end
      end
      2: begin
        if (m_led == FULL) begin m_led = 0; w = 1'b1; end
        else m_led = Dir ? (m_led / 2 + TOP) : ((m_led * 2 + 1) & FULL);
      end
      default: begin w = (m_led == FULL); m_led = FULL - m_led; end
    endcase
  endtask

  task automatic model_cycle();
    exp_t e;
    logic w;
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (Reset) reseed();
    else if (!Enable) begin m_led = 0; m_cnt = 0; m_mode = int'(Mode); end
    else if (int'(Mode) != m_mode) reseed();
    else if (!Hold) begin
      if (m_cnt >= (TD >> Speed) - 1) begin
        m_cnt = 0; e.step = 1'b1; advance(w); e.wrap = w;
      end else m_cnt++;
    end
    e.led = m_led[W-1:0];
    sb.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic en, input logic h, input logic [1:0] md,
                     input logic d, input logic [1:0] sp);
    Reset = r; Enable = en; Hold = h; Mode = md; Dir = d; Speed = sp;
    model_cycle();
    @(negedge CLK_in);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, Enable, Hold, Mode, Dir, Speed);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_in);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({LED, Step, Wrap} !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t: got LED=%h Step=%b Wrap=%b, expected LED=%h Step=%b Wrap=%b",
                   $time, LED, Step, Wrap, e.led, e.step, e.wrap);
        end
      end
    end
  end

  initial begin
    // Shift from reset
    cyc(1, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
    chk("reset_led", 16'(LED), 16'h01);
    run(32); chk("shift_half", 16'(LED), 16'h10);
    run(32); chk("shift_wrap", {7'd0, Wrap, LED}, {7'd0, 1'b1, 8'h01});

    // Bounce: top end after 7 steps, wrap at bit 0 after 14
    cyc(1, 1, 0, 1, 0, 0);
    run(56); chk("bounce_top", 16'(LED), 16'h80);
    run(8);  chk("bounce_leave_top", 16'(LED), 16'h40);
    run(48); chk("bounce_wrap", {7'd0, Wrap, LED}, {7'd0, 1'b1, 8'h01});

    // Fill toward LSB, speed jump mid-count
    cyc(1, 1, 0, 2, 1, 0);
    run(24); chk("fill_e0", 16'(LED), 16'hE0);
    run(5);
    cyc(0, 1, 0, 2, 1, 3); chk("speed_jump", {7'd0, Step, LED}, {7'd0, 1'b1, 8'hF0});
    run(5); chk("fill_wrap", {7'd0, Wrap, LED}, {7'd0, 1'b1, 8'h00});

    // Hold freezes mid-count
    cyc(1, 1, 0, 0, 0, 0);
    run(27);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0, 0);
    chk("hold_frozen", {7'd0, Step, LED}, {7'd0, 1'b0, 8'h08});
    cyc(0, 1, 0, 0, 0, 0); run(3); chk("hold_remaining", 16'(LED), 16'h08);
    run(1); chk("hold_release_step", {7'd0, Step, LED}, {7'd0, 1'b1, 8'h10});

    // Mode change under hold, then blink
    cyc(0, 1, 1, 3, 0, 0); chk("mode_chg_hold", 16'(LED), 16'h00);
    cyc(0, 1, 0, 3, 0, 0); run(7); chk("blink_on", 16'(LED), 16'hFF);
    run(8); chk("blink_wrap", {7'd0, Wrap, LED}, {7'd0, 1'b1, 8'h00});
    run(8); chk("blink_on2", 16'(LED), 16'hFF);

    // Enable drop and recovery
    cyc(1, 1, 0, 0, 0, 0); run(32);
    cyc(0, 0, 0, 0, 0, 0); chk("disable_dark", 16'(LED), 16'h00);
    run(3);
    cyc(0, 1, 0, 0, 0, 0); run(6); chk("reenable_dark", 16'(LED), 16'h00);
    run(1); chk("reenable_seed", {7'd0, Step, LED}, {7'd0, 1'b1, 8'h01});
    cyc(1, 0, 0, 0, 0, 0); chk("reset_beats_disable", 16'(LED), 16'h01);

    // Randomised soak
    for (int i = 0; i < 4000; i++) begin
      logic r, en, h, d;
      logic [1:0] md, sp;
      r = ($urandom_range(199) == 0);
      en = Enable; h = Hold; d = Dir; md = Mode; sp = Speed;
      if ($urandom_range(149) == 0) en = ~en;
      if ($urandom_range(39) == 0) h = ~h;
      if ($urandom_range(59) == 0) d = ~d;
      if ($urandom_range(119) == 0) md = 2'($urandom_range(3));
      if ($urandom_range(79) == 0) sp = 2'($urandom_range(3));
      cyc(r, en, h, md, d, sp);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK_in);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
